riscv_mc_controller: RTL and testbench

- Multi-cycle control FSM that sequences the RV32I datapath one instruction at a time.
- Decodes opcode/func3/func7 from the instruction register and drives every datapath select, enable and ALU op.
- Runs the data-memory chip-select/write handshake, waiting on mem_ready.
- Sits beside the datapath; replaces a purely combinational decoder so memory latency and PC/IR enables are handled.

---
 rtl/riscv_mc_controller_if.sv | 10 +
 rtl/riscv_mc_controller.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mc_controller_if.sv
// Data-memory access handshake between the multi-cycle controller and data memory.
// cs is held from MEM entry until the cycle mem_ready is high; wr qualifies cs.
interface riscv_mc_controller_if;
    logic cs;
    logic wr;
    logic mem_ready;

    modport master (output cs, output wr, input mem_ready);
    modport slave  (input cs, input wr, output mem_ready);
endinterface

// File: rtl/riscv_mc_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with registered datapath controls.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
module riscv_mc_controller #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [6:0]                   opcode,
    input  logic [2:0]                   func3,
    input  logic [6:0]                   func7,
    riscv_mc_controller_if.master        mem_bus,
    output logic                         pc_en,
    output logic                         ir_en,
    output logic                         rfwrite,
    output logic                         Use_Imm,
    output logic [1:0]                   sel_PC,
    output logic [1:0]                   wb_sel,
    output logic [2:0]                   Op_Extend,
    output logic [2:0]                   br_type,
    output logic [3:0]                   ALUop,
    output logic                         trap,
    output logic [31:0]                  cycle_cnt,
    output logic [31:0]                  instret_cnt,
    output logic [2:0]                   dbg_state_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam bit          TIMEOUT_EN   = (MEM_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_EN ? 32'(MEM_TIMEOUT - 1) : 32'd0;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_WB     = 2'd0,
        C_LOAD   = 2'd1,
        C_STORE  = 2'd2,
        C_BRANCH = 2'd3
    } class_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] sel_pc;
        logic       use_imm;
        logic [2:0] op_ext;
        logic [2:0] br_type;
        logic [1:0] wb_sel;
    } ctrl_t;

    state_t      state_q;
    class_t      cls_q;
    ctrl_t       ctrl_q;
    logic [31:0] wait_q;
    logic        ir_en_q;
    logic        pc_en_q;
    logic        rfwrite_q;
    logic        cs_q;
    logic        wr_q;
    logic        trap_q;

    ctrl_t       ctrl_d;
    class_t      cls_d;
    logic        illegal_d;
    logic        run;
    logic        store_done;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? 4'd1 : 4'd0;
            3'b001:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b100:  return 4'd5;
            3'b101:  return alt ? 4'd7 : 4'd6;
            3'b110:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    // Instruction register is stable during DECODE; this decode is latched at the DECODE edge.
    always_comb begin
        ctrl_d    = '0;
        cls_d     = C_WB;
        illegal_d = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_d.alu_op = alu_from_f3(func3, func7[5]);
                illegal_d     = (func7 != 7'b0000000) && (func7 != 7'b0100000);
            end
            OP_I: begin
                ctrl_d.use_imm = 1'b1;
                ctrl_d.alu_op  = alu_from_f3(func3, func7[5] && (func3 == 3'b101));
            end
            OP_LOAD: begin
                ctrl_d.use_imm = 1'b1;
                ctrl_d.wb_sel  = 2'd1;
                cls_d          = C_LOAD;
                illegal_d      = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
            end
            OP_STORE: begin
                ctrl_d.use_imm = 1'b1;
                ctrl_d.op_ext  = 3'd1;
                cls_d          = C_STORE;
                illegal_d      = (func3 > 3'b010);
            end
            OP_BRANCH: begin
                ctrl_d.sel_pc  = 2'd1;
                ctrl_d.use_imm = 1'b1;
                ctrl_d.op_ext  = 3'd3;
                cls_d          = C_BRANCH;
                case (func3)
                    3'b000:  ctrl_d.br_type = 3'd1;
                    3'b001:  ctrl_d.br_type = 3'd2;
                    3'b100:  ctrl_d.br_type = 3'd3;
                    3'b101:  ctrl_d.br_type = 3'd4;
                    3'b110:  ctrl_d.br_type = 3'd5;
                    3'b111:  ctrl_d.br_type = 3'd6;
                    default: illegal_d      = 1'b1;
                endcase
            end
            OP_JAL: begin
                ctrl_d.sel_pc  = 2'd1;
                ctrl_d.use_imm = 1'b1;
                ctrl_d.op_ext  = 3'd4;
                ctrl_d.br_type = 3'd7;
                ctrl_d.wb_sel  = 2'd2;
            end
            OP_JALR: begin
                ctrl_d.use_imm = 1'b1;
                ctrl_d.br_type = 3'd7;
                ctrl_d.wb_sel  = 2'd2;
            end
            OP_LUI: begin
                ctrl_d.sel_pc  = 2'd2;
                ctrl_d.use_imm = 1'b1;
                ctrl_d.op_ext  = 3'd2;
            end
            OP_AUIPC: begin
                ctrl_d.sel_pc  = 2'd1;
                ctrl_d.use_imm = 1'b1;
                ctrl_d.op_ext  = 3'd2;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_WB;
            ctrl_q    <= '0;
            wait_q    <= '0;
            // FETCH's strobe is preloaded; the reset mask hides it while reset is held.
            ir_en_q   <= 1'b1;
            pc_en_q   <= 1'b0;
            rfwrite_q <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            ir_en_q   <= 1'b0;
            pc_en_q   <= 1'b0;
            rfwrite_q <= 1'b0;
            case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    if (illegal_d) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                    end else begin
                        state_q <= S_EXEC;
                        ctrl_q  <= ctrl_d;
                        cls_q   <= cls_d;
                        pc_en_q <= (cls_d == C_BRANCH);
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_BRANCH: begin
                            state_q <= S_FETCH;
                            ir_en_q <= 1'b1;
                            ctrl_q  <= '0;
                        end
                        C_LOAD, C_STORE: begin
                            state_q <= S_MEM;
                            cs_q    <= 1'b1;
                            wr_q    <= (cls_q == C_STORE);
                            wait_q  <= '0;
                        end
                        default: begin
                            state_q   <= S_WB;
                            rfwrite_q <= 1'b1;
                            pc_en_q   <= 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_bus.mem_ready) begin
                        cs_q <= 1'b0;
                        wr_q <= 1'b0;
                        if (cls_q == C_LOAD) begin
                            state_q   <= S_WB;
                            rfwrite_q <= 1'b1;
                            pc_en_q   <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            ir_en_q <= 1'b1;
                            ctrl_q  <= '0;
                        end
                    end else if (TIMEOUT_EN && (wait_q == TIMEOUT_LAST)) begin
                        state_q <= S_TRAP;
                        trap_q  <= 1'b1;
                        cs_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        ctrl_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                    ir_en_q <= 1'b1;
                    ctrl_q  <= '0;
                end
                S_TRAP: state_q <= S_TRAP;
                default: begin
                    state_q <= S_FETCH;
                    ir_en_q <= 1'b1;
                end
            endcase
        end
    end

    // A store retires in the same cycle memory accepts it, so its PC strobe follows mem_ready.
    assign store_done = (state_q == S_MEM) && (cls_q == C_STORE) && mem_bus.mem_ready;
    assign run        = ~reset;

    assign ir_en       = ir_en_q & run;
    assign pc_en       = (pc_en_q | store_done) & run;
    assign rfwrite     = rfwrite_q & run;
    assign mem_bus.cs  = cs_q & run;
    assign mem_bus.wr  = wr_q & run;
    assign trap        = trap_q & run;
    assign ALUop       = ctrl_q.alu_op & {4{run}};
    assign sel_PC      = ctrl_q.sel_pc & {2{run}};
    assign Use_Imm     = ctrl_q.use_imm & run;
    assign Op_Extend   = ctrl_q.op_ext & {3{run}};
    assign br_type     = ctrl_q.br_type & {3{run}};
    assign wb_sel      = ctrl_q.wb_sel & {2{run}};
    assign dbg_state_o = state_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (pc_en) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_q & {32{run}};
    assign instret_cnt = instret_q & {32{run}};
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench for riscv_mc_controller: per-cycle expected control vectors via a scoreboard queue.
module tb_riscv_mc_controller;

    localparam int W = 21;
    localparam logic [W-1:0] V_PC   = 21'h100000;
    localparam logic [W-1:0] V_IR   = 21'h080000;
    localparam logic [W-1:0] V_RF   = 21'h040000;
    localparam logic [W-1:0] V_CS   = 21'h000004;
    localparam logic [W-1:0] V_WR   = 21'h000002;
    localparam logic [W-1:0] V_TRAP = 21'h000001;
    localparam int K_BR = 0;
    localparam int K_WB = 1;
    localparam int K_LD = 2;
    localparam int K_ST = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'h00;
    logic [2:0]  func3 = 3'h0;
    logic [6:0]  func7 = 7'h00;
    logic        pc_en, ir_en, rfwrite, Use_Imm, trap;
    logic [1:0]  sel_PC, wb_sel;
    logic [2:0]  Op_Extend, br_type, dbg_state;
    logic [3:0]  ALUop;
    logic [31:0] cycle_cnt, instret_cnt;
    logic [W-1:0] act;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    riscv_mc_controller_if mif ();

    riscv_mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
        .mem_bus(mif), .pc_en(pc_en), .ir_en(ir_en), .rfwrite(rfwrite), .Use_Imm(Use_Imm),
        .sel_PC(sel_PC), .wb_sel(wb_sel), .Op_Extend(Op_Extend), .br_type(br_type),
        .ALUop(ALUop), .trap(trap), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
        .dbg_state_o(dbg_state)
    );

    assign act = {pc_en, ir_en, rfwrite, Use_Imm, sel_PC, wb_sel, Op_Extend, br_type,
                  ALUop, mif.cs, mif.wr, trap};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic void check(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
        end
    endfunction

    // Monitor: one expected control vector per pushed cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                check(name_q.pop_front(), 64'(act), 64'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [W-1:0] ctl(input logic [3:0] alu, input logic [1:0] sp,
                                         input logic ui, input logic [2:0] oe,
                                         input logic [2:0] bt, input logic [1:0] wb);
        return {3'b000, ui, sp, wb, oe, bt, alu, 3'b000};
    endfunction

    task automatic cyc(input string nm, input logic [W-1:0] e, input logic rst, input logic mr);
        @(posedge clk);
        #1;
        reset = rst;
        mif.mem_ready = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_reset();
        cyc("reset0", '0, 1'b1, 1'b0);
        cyc("reset1", '0, 1'b1, 1'b0);
    endtask

    // Fetch and decode cycles shared by every instruction; the IR value is presented in DECODE.
    task automatic front(input string nm, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic noise);
        cyc({nm, ":fetch"}, V_IR, 1'b0, noise);
        cyc({nm, ":decode"}, '0, 1'b0, noise);
        opcode = op;
        func3  = f3;
        func7  = f7;
    endtask

    task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int kind, input int waits,
                             input logic [W-1:0] c);
        logic noise;
        noise = (kind == K_WB || kind == K_BR);
        front(nm, op, f3, f7, noise);
        if (kind == K_BR) begin
            cyc({nm, ":exec"}, c | V_PC, 1'b0, noise);
        end else begin
            cyc({nm, ":exec"}, c, 1'b0, noise);
        end
        // Scramble the IR fields: controls must stay latched from DECODE.
        opcode = 7'h7F;
        func3  = ~f3;
        func7  = ~f7;
        if (kind == K_WB) begin
            cyc({nm, ":wb"}, c | V_RF | V_PC, 1'b0, 1'b1);
        end else if (kind == K_LD) begin
            for (int i = 0; i < waits; i++) cyc({nm, ":mem_wait"}, c | V_CS, 1'b0, 1'b0);
            cyc({nm, ":mem_done"}, c | V_CS, 1'b0, 1'b1);
            cyc({nm, ":wb"}, c | V_RF | V_PC, 1'b0, 1'b0);
        end else if (kind == K_ST) begin
            for (int i = 0; i < waits; i++) cyc({nm, ":mem_wait"}, c | V_CS | V_WR, 1'b0, 1'b0);
            cyc({nm, ":mem_done"}, c | V_CS | V_WR | V_PC, 1'b0, 1'b1);
        end
    endtask

    task automatic run_illegal(input string nm, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7);
        front(nm, op, f3, f7, 1'b0);
        for (int i = 0; i < 3; i++) cyc({nm, ":trap"}, V_TRAP, 1'b0, 1'b0);
        do_reset();
    endtask

    initial begin
        logic [31:0] exp_cyc;
        logic [31:0] exp_ret;
        mif.mem_ready = 1'b0;
        do_reset();

        run_instr("add",   7'b0110011, 3'b000, 7'b0000000, K_WB, 0, ctl(4'd0, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0));
        run_instr("sub",   7'b0110011, 3'b000, 7'b0100000, K_WB, 0, ctl(4'd1, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0));
        run_instr("addi",  7'b0010011, 3'b000, 7'b0100000, K_WB, 0, ctl(4'd0, 2'd0, 1'b1, 3'd0, 3'd0, 2'd0));
        run_instr("srai",  7'b0010011, 3'b101, 7'b0100000, K_WB, 0, ctl(4'd7, 2'd0, 1'b1, 3'd0, 3'd0, 2'd0));
        run_instr("srl",   7'b0110011, 3'b101, 7'b0000000, K_WB, 0, ctl(4'd6, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0));
        run_instr("sltu",  7'b0110011, 3'b011, 7'b0000000, K_WB, 0, ctl(4'd4, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0));
        run_instr("xori",  7'b0010011, 3'b100, 7'b0100000, K_WB, 0, ctl(4'd5, 2'd0, 1'b1, 3'd0, 3'd0, 2'd0));
        run_instr("and",   7'b0110011, 3'b111, 7'b0000000, K_WB, 0, ctl(4'd9, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0));
        run_instr("lw",    7'b0000011, 3'b010, 7'b0000000, K_LD, 3, ctl(4'd0, 2'd0, 1'b1, 3'd0, 3'd0, 2'd1));
        run_instr("sw",    7'b0100011, 3'b010, 7'b0000000, K_ST, 0, ctl(4'd0, 2'd0, 1'b1, 3'd1, 3'd0, 2'd0));
        run_instr("sb_w1", 7'b0100011, 3'b000, 7'b0000000, K_ST, 1, ctl(4'd0, 2'd0, 1'b1, 3'd1, 3'd0, 2'd0));
        run_instr("beq",   7'b1100011, 3'b000, 7'b0000000, K_BR, 0, ctl(4'd0, 2'd1, 1'b1, 3'd3, 3'd1, 2'd0));
        run_instr("bgeu",  7'b1100011, 3'b111, 7'b0000000, K_BR, 0, ctl(4'd0, 2'd1, 1'b1, 3'd3, 3'd6, 2'd0));
        run_instr("jal",   7'b1101111, 3'b000, 7'b0000000, K_WB, 0, ctl(4'd0, 2'd1, 1'b1, 3'd4, 3'd7, 2'd2));
        run_instr("jalr",  7'b1100111, 3'b000, 7'b0000000, K_WB, 0, ctl(4'd0, 2'd0, 1'b1, 3'd0, 3'd7, 2'd2));
        run_instr("lui",   7'b0110111, 3'b000, 7'b0000000, K_WB, 0, ctl(4'd0, 2'd2, 1'b1, 3'd2, 3'd0, 2'd0));
        run_instr("auipc", 7'b0010111, 3'b000, 7'b0000000, K_WB, 0, ctl(4'd0, 2'd1, 1'b1, 3'd2, 3'd0, 2'd0));

        run_illegal("ill_op0",    7'b0000000, 3'b000, 7'b0000000);
        run_illegal("ill_br010",  7'b1100011, 3'b010, 7'b0000000);
        run_illegal("ill_st011",  7'b0100011, 3'b011, 7'b0000000);
        run_illegal("ill_ld110",  7'b0000011, 3'b110, 7'b0000000);
        run_illegal("ill_rf7",    7'b0110011, 3'b000, 7'b0000001);

        // Load that never completes: four MEM cycles, then sticky trap.
        front("lw_to", 7'b0000011, 3'b010, 7'b0000000, 1'b0);
        cyc("lw_to:exec", ctl(4'd0, 2'd0, 1'b1, 3'd0, 3'd0, 2'd1), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("lw_to:mem", ctl(4'd0, 2'd0, 1'b1, 3'd0, 3'd0, 2'd1) | V_CS, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw_to:trap", V_TRAP, 1'b0, 1'b0);
        do_reset();

        // Reset while a load waits in MEM; the late mem_ready must not be taken.
        front("lw_rst", 7'b0000011, 3'b000, 7'b0000000, 1'b0);
        cyc("lw_rst:exec", ctl(4'd0, 2'd0, 1'b1, 3'd0, 3'd0, 2'd1), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc("lw_rst:mem", ctl(4'd0, 2'd0, 1'b1, 3'd0, 3'd0, 2'd1) | V_CS, 1'b0, 1'b0);
        cyc("lw_rst:reset", '0, 1'b1, 1'b1);
        run_instr("or_after_rst", 7'b0110011, 3'b110, 7'b0000000, K_WB, 0, ctl(4'd8, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0));

        // Counters after reset + one ALU instruction, sampled in the next FETCH.
        do_reset();
        run_instr("add_cnt", 7'b0110011, 3'b000, 7'b0000000, K_WB, 0, ctl(4'd0, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0));
        cyc("cnt:fetch", V_IR, 1'b0, 1'b0);
`ifdef MC_PERF_CNT_EN
        exp_cyc = 32'd4;
        exp_ret = 32'd1;
`else
        exp_cyc = 32'd0;
        exp_ret = 32'd0;
`endif
        check("cycle_cnt", 64'(cycle_cnt), 64'(exp_cyc));
        check("instret_cnt", 64'(instret_cnt), 64'(exp_ret));

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
